// File: rtl/seg_pkg.sv
// Shared segment-display definitions: SPGFEDCBA bit positions, the decimal
// digit font, the blank pattern and the segment-bus width.
package seg_pkg;

  // Width of one segment-display bus: S, P, G, F, E, D, C, B, A
  localparam int SEG_W = 9;

  // Bit positions inside the SPGFEDCBA bus
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_P = 7;
  localparam int SEG_S = 8;

  // Active-high GFEDCBA patterns for the decimal digits
  localparam logic [6:0] FONT_0 = 7'h3F;
  localparam logic [6:0] FONT_1 = 7'h06;
  localparam logic [6:0] FONT_2 = 7'h5B;
  localparam logic [6:0] FONT_3 = 7'h4F;
  localparam logic [6:0] FONT_4 = 7'h66;
  localparam logic [6:0] FONT_5 = 7'h6D;
  localparam logic [6:0] FONT_6 = 7'h7D;
  localparam logic [6:0] FONT_7 = 7'h07;
  localparam logic [6:0] FONT_8 = 7'h7F;
  localparam logic [6:0] FONT_9 = 7'h6F;

  // All segments off
  localparam logic [6:0] FONT_BLANK = 7'h00;

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD digit to GFEDCBA lookup; codes 10..15 show blank.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Font lookup, anything that is not a decimal digit is blanked
  always_comb begin
    seg_o = FONT_BLANK;
    case (bcd_i)
      4'd0:    seg_o = FONT_0;
      4'd1:    seg_o = FONT_1;
      4'd2:    seg_o = FONT_2;
      4'd3:    seg_o = FONT_3;
      4'd4:    seg_o = FONT_4;
      4'd5:    seg_o = FONT_5;
      4'd6:    seg_o = FONT_6;
      4'd7:    seg_o = FONT_7;
      4'd8:    seg_o = FONT_8;
      4'd9:    seg_o = FONT_9;
      default: seg_o = FONT_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_seg_counter.sv
// Two-digit BCD counter advanced by an internal tick prescaler, driving two
// registered SPGFEDCBA segment displays (tens on led_1, ones on led_2).
module bcd_seg_counter
  import seg_pkg::*;
#(
  parameter int CLK_DIV    = 25000000,
  parameter int MAX_COUNT  = 59,
  parameter int LEAD_BLANK = 0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic             clr_in,
  output logic             tick_out,
  output logic             carry_out,
  output logic [7:0]       cnt_bcd,
  output logic [SEG_W-1:0] Segment_led_1,
  output logic [SEG_W-1:0] Segment_led_2
);

  localparam int             PW       = $clog2(CLK_DIV);
  localparam logic [PW-1:0]  PRE_TERM = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]  PRE_HALF = PW'(CLK_DIV / 2);
  localparam logic [7:0]     MAX_BCD  = {4'(MAX_COUNT / 10), 4'(MAX_COUNT % 10)};
  // Tens display after reset: blank when leading zeros are suppressed
  localparam logic [SEG_W-1:0] SEG1_RST = (LEAD_BLANK != 0) ? 9'h000 : {2'b00, FONT_0};
  localparam logic [SEG_W-1:0] SEG2_RST = {2'b00, FONT_0};

  logic [PW-1:0]    pre_q, pre_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             carry_q, carry_d;
  logic [SEG_W-1:0] seg1_q, seg1_d;
  logic [SEG_W-1:0] seg2_q, seg2_d;
  logic [6:0]       tens_seg_s;
  logic [6:0]       ones_seg_s;

  seg_decoder u_dec_tens (
    .bcd_i (cnt_q[7:4]),
    .seg_o (tens_seg_s)
  );

  seg_decoder u_dec_ones (
    .bcd_i (cnt_q[3:0]),
    .seg_o (ones_seg_s)
  );

  // Prescaler, BCD count and display next-state
  always_comb begin
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    if (en_in) begin
      if (pre_q == PRE_TERM) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (cnt_q == MAX_BCD) begin
          cnt_d   = 8'h00;
          carry_d = 1'b1;
        end else if (cnt_q[3:0] == 4'd9) begin
          cnt_d = {cnt_q[7:4] + 4'd1, 4'd0};
        end else begin
          cnt_d = {cnt_q[7:4], cnt_q[3:0] + 4'd1};
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end else begin
      pre_d = pre_q;
    end

    // Displays follow the current count; DP blinks during the first half period
    seg1_d = {1'b0, 1'b0, tens_seg_s};
    if ((LEAD_BLANK != 0) && (cnt_q[7:4] == 4'd0)) begin
      seg1_d = 9'h000;
    end else begin
      seg1_d = {1'b0, 1'b0, tens_seg_s};
    end
    seg2_d = {1'b0, (en_in && (pre_q < PRE_HALF)), ones_seg_s};
  end

  // State and output registers; reset beats clear beats enable
  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in) begin
      pre_q   <= '0;
      cnt_q   <= 8'h00;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
      seg1_q  <= SEG1_RST;
      seg2_q  <= SEG2_RST;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
      seg1_q  <= seg1_d;
      seg2_q  <= seg2_d;
    end
  end

  assign tick_out      = tick_q;
  assign carry_out     = carry_q;
  assign cnt_bcd       = cnt_q;
  assign Segment_led_1 = seg1_q;
  assign Segment_led_2 = seg2_q;

endmodule
